// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-side and
// D-side L1 caches. The winner's command is latched and held for the whole access.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE, DRAIN} state_t;

  state_t              state;
  logic                cmd_rd;
  logic                cmd_wr;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [LINE_W-1:0]   cmd_wdata;
  logic                owner;
  logic                last;

  logic                i_req;
  logic                d_req;
  logic                grant_d;

  // D wins when it is alone, or on a tie when I was served last.
  function automatic logic pick_d(input logic ireq, input logic dreq, input logic lst);
    return dreq && (!ireq || !lst);
  endfunction

  assign i_req   = i_read | i_write;
  assign d_req   = d_read | d_write;
  assign grant_d = pick_d(i_req, d_req, last);

  // cmd_rd/cmd_wr double as the pmem strobes, so they are cleared on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            if (grant_d) begin
              cmd_wr    <= d_write;
              cmd_rd    <= d_read & ~d_write;
              cmd_addr  <= d_addr;
              cmd_wdata <= d_wdata;
            end else begin
              cmd_wr    <= i_write;
              cmd_rd    <= i_read & ~i_write;
              cmd_addr  <= i_addr;
              cmd_wdata <= i_wdata;
            end
            owner <= grant_d;
            last  <= grant_d;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (pmem_resp) begin
            cmd_rd <= 1'b0;
            cmd_wr <= 1'b0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_read    = cmd_rd;
  assign pmem_write   = cmd_wr;
  assign pmem_address = cmd_addr;
  assign pmem_wdata   = cmd_wdata;

  // Completion passes straight through to the owner with no added latency.
  assign i_resp = (state == SERVE) && pmem_resp && !owner;
  assign d_resp = (state == SERVE) && pmem_resp &&  owner;
  assign rdata  = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level round-robin model.
module tb_pmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata;
  logic          i_resp, d_resp;
  logic [LW-1:0] rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  int   total = 0;
  int   bad   = 0;
  logic m_last;

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_resp(d_resp),
    .rdata(rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One arbitration round from IDLE: grant, k SERVE cycles, DRAIN, back to IDLE.
  task automatic do_txn(input int k, input logic [LW-1:0] line, input bit mutate,
                        input logic [AW-1:0] new_addr);
    logic          ireq, dreq, side, exp_rd, exp_wr;
    logic [AW-1:0] ea;
    logic [LW-1:0] ew;
    ireq = i_read | i_write;
    dreq = d_read | d_write;
    if (ireq && dreq) side = ~m_last;
    else              side = dreq;
    exp_wr = side ? d_write : i_write;
    exp_rd = (side ? d_read : i_read) & ~exp_wr;
    ea     = side ? d_addr : i_addr;
    ew     = side ? d_wdata : i_wdata;
    chk1("idle_pmem_read", pmem_read, 1'b0);
    chk1("idle_pmem_write", pmem_write, 1'b0);
    step();
    if (mutate) begin
      if (side) begin d_addr = new_addr; d_wdata = rnd_line(); end
      else      begin i_addr = new_addr; i_wdata = rnd_line(); end
    end
    for (int c = 1; c <= k; c++) begin
      if (c == k) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line;
      end
      #1;
      chk1("serve_pmem_read", pmem_read, exp_rd);
      chk1("serve_pmem_write", pmem_write, exp_wr);
      chka("serve_pmem_address", pmem_address, ea);
      chkw("serve_pmem_wdata", pmem_wdata, ew);
      chk1("serve_i_resp", i_resp, (c == k) && !side);
      chk1("serve_d_resp", d_resp, (c == k) && side);
      if (c == k) chkw("resp_rdata", rdata, line);
      step();
    end
    // pmem_resp left high in DRAIN must not produce another completion
    if (side) begin d_read = 1'b0; d_write = 1'b0; end
    else      begin i_read = 1'b0; i_write = 1'b0; end
    #1;
    chk1("drain_pmem_read", pmem_read, 1'b0);
    chk1("drain_pmem_write", pmem_write, 1'b0);
    chk1("drain_i_resp", i_resp, 1'b0);
    chk1("drain_d_resp", d_resp, 1'b0);
    pmem_resp  = 1'b0;
    pmem_rdata = rnd_line();
    m_last     = side;
    step();
  endtask

  initial begin
    int cmd;
    rst_n = 1'b0;
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    pmem_resp = 1'b1; pmem_rdata = rnd_line();
    m_last = 1'b1;
    #2;
    chk1("rst_pmem_read", pmem_read, 1'b0);
    chk1("rst_pmem_write", pmem_write, 1'b0);
    chka("rst_pmem_address", pmem_address, 16'h0000);
    chkw("rst_pmem_wdata", pmem_wdata, '0);
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Tie straight after reset: I first, then the D write
    i_read = 1'b1; i_addr = 16'h1230;
    d_write = 1'b1; d_addr = 16'h4000; d_wdata = {16{8'h0F}};
    do_txn(2, rnd_line(), 1'b0, '0);
    do_txn(2, rnd_line(), 1'b0, '0);

    // Single I read with a 3-cycle pmem
    i_read = 1'b1; i_addr = 16'h1230;
    do_txn(3, {16{8'hA5}}, 1'b0, '0);

    // Address changed by the requester mid-SERVE
    i_read = 1'b1; i_addr = 16'h1230;
    do_txn(3, rnd_line(), 1'b1, 16'h9999);

    // Read and write together: the write wins
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h2222; d_wdata = rnd_line();
    do_txn(1, rnd_line(), 1'b0, '0);

    // Spurious pmem_resp in IDLE
    pmem_resp = 1'b1;
    #1;
    chk1("spur_i_resp", i_resp, 1'b0);
    chk1("spur_d_resp", d_resp, 1'b0);
    step();
    chk1("spur_pmem_read", pmem_read, 1'b0);
    chk1("spur_pmem_write", pmem_write, 1'b0);
    pmem_resp = 1'b0;

    // Both sides requesting continuously for 6 rounds
    i_read = 1'b1; i_addr = 16'h0100;
    d_write = 1'b1; d_addr = 16'h0200; d_wdata = rnd_line();
    for (int n = 0; n < 6; n++) begin
      do_txn(1 + (n % 3), rnd_line(), 1'b0, '0);
      if (m_last) d_write = 1'b1;
      else        i_read  = 1'b1;
    end
    i_read = 1'b0; d_write = 1'b0;

    // Asynchronous reset in the middle of a D write
    d_write = 1'b1; d_addr = 16'h4000; d_wdata = {16{8'h0F}};
    step();
    chk1("pre_rst_pmem_write", pmem_write, 1'b1);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_pmem_write", pmem_write, 1'b0);
    chka("async_rst_pmem_address", pmem_address, 16'h0000);
    pmem_resp = 1'b1;
    #1;
    chk1("async_rst_d_resp", d_resp, 1'b0);
    #8;
    rst_n = 1'b1;
    pmem_resp = 1'b0;
    m_last = 1'b1;
    do_txn(2, rnd_line(), 1'b0, '0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!(i_read | i_write) && ($urandom % 2 == 0)) begin
        cmd = $urandom_range(1, 3);
        i_read = cmd[0]; i_write = cmd[1];
        i_addr = 16'($urandom); i_wdata = rnd_line();
      end
      if (!(d_read | d_write) && ($urandom % 2 == 0)) begin
        cmd = $urandom_range(1, 3);
        d_read = cmd[0]; d_write = cmd[1];
        d_addr = 16'($urandom); d_wdata = rnd_line();
      end
      if (!(i_read | i_write | d_read | d_write)) begin
        i_read = 1'b1; i_addr = 16'($urandom);
      end
      do_txn($urandom_range(1, 4), rnd_line(), ($urandom % 4) == 0, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
